// File: rtl/spi_ram_burst.sv
// Command-driven word RAM with separate write/read pointers and a one-cycle read path.
// Optional macro SPI_RAM_AUTO_INC_EN: post-increment pointers (wrapping at MEM_DEPTH-1) on data commands.
module spi_ram_burst #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  localparam int PAY_W = (MEM_WIDTH > ADDR_SIZE) ? MEM_WIDTH : ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [PAY_W+1:0]     din,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] wr_addr_o,
  output logic [ADDR_SIZE-1:0] rd_addr_o,
  output logic                 seq_err,
  output logic                 addr_err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    RD_ARMED = 1'b1
  } state_e;

  localparam logic [PAY_W:0] DEPTH_LIMIT = (PAY_W+1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_SIZE-1:0] rdPtr_q, rdPtr_d;
  logic [MEM_WIDTH-1:0] dout_q, dout_d;
  logic                 txValid_q, txValid_d;
  logic                 seqErr_q, seqErr_d;
  logic                 addrErr_q, addrErr_d;
  logic                 memWe;

  opcode_e              opcode;
  logic [PAY_W-1:0]     payload;
  logic                 addrOutOfRange;

  assign opcode         = opcode_e'(din[PAY_W+1:PAY_W]);
  assign payload        = din[PAY_W-1:0];
  assign addrOutOfRange = ({1'b0, payload} >= DEPTH_LIMIT);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  logic [ADDR_SIZE-1:0] wrPtrInc, rdPtrInc;
  assign wrPtrInc = (wrPtr_q == LAST_ADDR) ? '0 : wrPtr_q + 1'b1;
  assign rdPtrInc = (rdPtr_q == LAST_ADDR) ? '0 : rdPtr_q + 1'b1;
`endif

  // Decode one command per valid cycle; reset suppresses the memory write too.
  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    dout_d    = dout_q;
    txValid_d = 1'b0;
    seqErr_d  = 1'b0;
    addrErr_d = 1'b0;
    memWe     = 1'b0;
    if (rx_valid && !rst) begin
      case (opcode)
        OP_WR_ADDR: begin
          if (addrOutOfRange) addrErr_d = 1'b1;
          else                wrPtr_d   = din[ADDR_SIZE-1:0];
        end
        OP_WR_DATA: begin
          memWe = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          wrPtr_d = wrPtrInc;
`else
          wrPtr_d = wrPtr_q;
`endif
        end
        OP_RD_ADDR: begin
          if (addrOutOfRange) begin
            addrErr_d = 1'b1;
          end else begin
            rdPtr_d = din[ADDR_SIZE-1:0];
            state_d = RD_ARMED;
          end
        end
        OP_RD_DATA: begin
          if (state_q == RD_ARMED) begin
            dout_d    = mem[rdPtr_q];
            txValid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            rdPtr_d = rdPtrInc;
`else
            rdPtr_d = rdPtr_q;
`endif
          end else begin
            seqErr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      dout_q    <= '0;
      txValid_q <= 1'b0;
      seqErr_q  <= 1'b0;
      addrErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      dout_q    <= dout_d;
      txValid_q <= txValid_d;
      seqErr_q  <= seqErr_d;
      addrErr_q <= addrErr_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (memWe) mem[wrPtr_q] <= din[MEM_WIDTH-1:0];
  end

  assign dout      = dout_q;
  assign tx_valid  = txValid_q;
  assign wr_addr_o = wrPtr_q;
  assign rd_addr_o = rdPtr_q;
  assign seq_err   = seqErr_q;
  assign addr_err  = addrErr_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: directed scenarios then random commands
// compared against a behavioural model of the command set.
module tb_spi_ram_burst;

  localparam int DEPTH = 200;
`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [9:0] din;
  logic [7:0] dout;
  logic       tx_valid;
  logic [7:0] wr_addr_o;
  logic [7:0] rd_addr_o;
  logic       seq_err;
  logic       addr_err;

  int compareCount = 0;
  int errCount     = 0;

  logic [7:0] memModel [DEPTH];
  int         wp, rp;
  bit         armed;
  logic [7:0] expDout;
  logic       expTx, expSeq, expAddrErr;

  spi_ram_burst #(.MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .din       (din),
    .dout      (dout),
    .tx_valid  (tx_valid),
    .wr_addr_o (wr_addr_o),
    .rd_addr_o (rd_addr_o),
    .seq_err   (seq_err),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour: what each edge should do, stated in terms of the command set.
  task automatic modelStep(input bit r, input bit v, input logic [1:0] op, input logic [7:0] pay);
    expTx      = 1'b0;
    expSeq     = 1'b0;
    expAddrErr = 1'b0;
    if (r) begin
      expDout = 8'h00;
      wp      = 0;
      rp      = 0;
      armed   = 1'b0;
    end else if (v) begin
      case (op)
        2'd0: if (int'(pay) >= DEPTH) expAddrErr = 1'b1; else wp = int'(pay);
        2'd1: begin
          memModel[wp] = pay;
          if (AUTO_INC) wp = (wp + 1) % DEPTH;
        end
        2'd2: if (int'(pay) >= DEPTH) expAddrErr = 1'b1;
              else begin rp = int'(pay); armed = 1'b1; end
        default: begin
          if (armed) begin
            expDout = memModel[rp];
            expTx   = 1'b1;
            if (AUTO_INC) rp = (rp + 1) % DEPTH;
          end else begin
            expSeq = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    compareCount++;
    assert (dout === expDout) else begin
      errCount++; $error("[TB] FAIL %s dout got %0h exp %0h", tag, dout, expDout);
    end
    compareCount++;
    assert (tx_valid === expTx) else begin
      errCount++; $error("[TB] FAIL %s tx_valid got %0b exp %0b", tag, tx_valid, expTx);
    end
    compareCount++;
    assert (seq_err === expSeq) else begin
      errCount++; $error("[TB] FAIL %s seq_err got %0b exp %0b", tag, seq_err, expSeq);
    end
    compareCount++;
    assert (addr_err === expAddrErr) else begin
      errCount++; $error("[TB] FAIL %s addr_err got %0b exp %0b", tag, addr_err, expAddrErr);
    end
    compareCount++;
    assert (wr_addr_o === 8'(wp)) else begin
      errCount++; $error("[TB] FAIL %s wr_addr_o got %0h exp %0h", tag, wr_addr_o, 8'(wp));
    end
    compareCount++;
    assert (rd_addr_o === 8'(rp)) else begin
      errCount++; $error("[TB] FAIL %s rd_addr_o got %0h exp %0h", tag, rd_addr_o, 8'(rp));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] op,
                               input logic [7:0] pay, input string tag);
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    din      = {op, pay};
    @(posedge clk);
    #1;
    modelStep(r, v, op, pay);
    checkOutput(tag);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    din      = '0;
    wp = 0; rp = 0; armed = 1'b0; expDout = 8'h00;
    expTx = 1'b0; expSeq = 1'b0; expAddrErr = 1'b0;

    // Reset with a coincident read command: command must be discarded.
    applyStimulus(1, 1, 2'd3, 8'h00, "reset_with_rd_data");
    applyStimulus(0, 0, 2'd0, 8'h00, "after_reset_idle");

    // Read before any read address: sequence error, dout untouched.
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_data_unarmed");
    applyStimulus(0, 0, 2'd0, 8'h00, "seq_err_drops");

    // Out-of-range addresses leave pointers alone.
    applyStimulus(0, 1, 2'd0, 8'hC8, "wr_addr_oor");
    applyStimulus(0, 0, 2'd0, 8'h00, "addr_err_drops");
    applyStimulus(0, 1, 2'd2, 8'hFF, "rd_addr_oor");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_after_bad_addr");

    // Fill every location with known data.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 2'd0, 8'(i), "fill_addr");
      applyStimulus(0, 1, 2'd1, 8'($urandom_range(0, 255)), "fill_data");
    end

    // Basic write then read-back.
    applyStimulus(0, 1, 2'd0, 8'h10, "wr_addr_10");
    applyStimulus(0, 1, 2'd1, 8'hA5, "wr_data_a5");
    applyStimulus(0, 1, 2'd2, 8'h10, "rd_addr_10");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_data_a5");
    applyStimulus(0, 0, 2'd0, 8'h00, "tx_valid_pulse_ends");
    applyStimulus(0, 0, 2'd0, 8'h00, "dout_holds");

    // Burst of reads at one address.
    applyStimulus(0, 1, 2'd2, 8'h05, "rd_addr_05");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'd3, 8'h00, "burst_read");
    applyStimulus(0, 0, 2'd0, 8'h00, "burst_done");

    // Pointer wrap at the top of memory.
    applyStimulus(0, 1, 2'd0, 8'(DEPTH - 1), "wr_addr_top");
    applyStimulus(0, 1, 2'd1, 8'h11, "wr_data_11");
    applyStimulus(0, 1, 2'd1, 8'h22, "wr_data_22");
    applyStimulus(0, 1, 2'd2, 8'(DEPTH - 1), "rd_addr_top");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_top");
    applyStimulus(0, 1, 2'd2, 8'h00, "rd_addr_zero");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_zero");

    // Write immediately followed by read of the same word.
    applyStimulus(0, 1, 2'd2, 8'h42, "rd_addr_42");
    applyStimulus(0, 1, 2'd0, 8'h42, "wr_addr_42");
    applyStimulus(0, 1, 2'd1, 8'h3C, "wr_data_3c");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_after_wr");

    // Reset while a read result is pending, then confirm read arming was cleared.
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_before_reset");
    applyStimulus(1, 1, 2'd3, 8'h00, "reset_mid_read");
    applyStimulus(0, 1, 2'd3, 8'h00, "rd_after_reset_unarmed");

    // Random command traffic.
    for (int n = 0; n < 3000; n++) begin
      bit         r;
      bit         v;
      logic [1:0] op;
      logic [7:0] pay;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      pay = 8'($urandom_range(0, 255));
      applyStimulus(r, v, op, pay, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 SHALL provide parameter MEM_WIDTH, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_SIZE, default 8, address width in bits.
REQ-003 SHALL provide parameter MEM_DEPTH, default 256, number of words; legal range 2..2**ADDR_SIZE.
REQ-004 SHALL define local PAY_W = max(MEM_WIDTH, ADDR_SIZE).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx_valid  input  1  din qualifier; one command per high cycle.
REQ-008 SHALL have port din  input  PAY_W+2  command: din[PAY_W+1:PAY_W] opcode, low bits payload.
REQ-009 SHALL have port dout  output  MEM_WIDTH  read data.
REQ-010 SHALL have port tx_valid  output  1  dout valid pulse.
REQ-011 SHALL have port wr_addr_o  output  ADDR_SIZE  current write pointer.
REQ-012 SHALL have port rd_addr_o  output  ADDR_SIZE  current read pointer.
REQ-013 SHALL have port seq_err  output  1  illegal-sequence pulse.
REQ-014 SHALL have port addr_err  output  1  out-of-range address pulse.

Function
REQ-015 SHALL decode opcodes 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA; commands ignored while rx_valid low.
REQ-016 SHALL keep separate write and read pointers; WR_ADDR loads wr pointer, RD_ADDR loads rd pointer from din[ADDR_SIZE-1:0] at the accepting edge.
REQ-017 SHALL, on WR_ADDR/RD_ADDR with payload >= MEM_DEPTH, leave pointer unchanged and pulse addr_err high for exactly the next cycle.
REQ-018 SHALL, on WR_DATA, write din[MEM_WIDTH-1:0] to mem[wr pointer] at the accepting edge; visible to a RD_DATA in the following cycle.
REQ-019 SHALL implement FSM states IDLE, RD_ARMED: rst -> IDLE; accepted RD_ADDR (in range) -> RD_ARMED; stays RD_ARMED until reset.
REQ-020 SHALL, on RD_DATA in RD_ARMED, drive dout = mem[rd pointer] and tx_valid = 1 in the cycle after acceptance (latency 1).
REQ-021 SHALL, on RD_DATA in IDLE, leave dout unchanged, keep tx_valid 0, pulse seq_err for one cycle.
REQ-022 SHALL drive tx_valid as single-cycle pulse; low in every cycle not immediately following an accepted RD_DATA.
REQ-023 SHALL hold dout at last read value between reads.
REQ-024 SHALL accept back-to-back commands every cycle with no stall.
REQ-025 SHALL, on RD_DATA following WR_DATA to the same address in the preceding cycle, return the newly written word.

Reset
REQ-026 SHALL, with rst high at a posedge, set dout = 0, tx_valid = 0, seq_err = 0, addr_err = 0, both pointers = 0, FSM = IDLE on that edge.
REQ-027 SHALL give rst priority over any coincident command; that command is discarded.
REQ-028 SHALL NOT clear memory contents on reset.
REQ-029 SHALL discard a read in flight when rst asserts mid-operation; tx_valid stays 0.

Configuration
REQ-030 SHALL honour macro SPI_RAM_AUTO_INC_EN.
REQ-031 SHALL, with SPI_RAM_AUTO_INC_EN defined, increment wr pointer after each WR_DATA and rd pointer after each accepted RD_DATA, wrapping MEM_DEPTH-1 -> 0.
REQ-032 SHALL, without SPI_RAM_AUTO_INC_EN, hold both pointers constant across WR_DATA/RD_DATA.

Verification
REQ-033 SHALL cover: rst=1 one cycle with RD_DATA on din -> next cycle dout=0, tx_valid=0, rd_addr_o=0, seq_err=0.
REQ-034 SHALL cover: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> dout=0xA5, tx_valid=1 one cycle after RD_DATA only.
REQ-035 SHALL cover: RD_DATA after reset with no RD_ADDR -> seq_err=1 one cycle, tx_valid=0, dout unchanged.
REQ-036 SHALL cover (AUTO_INC_EN, MEM_DEPTH=256): WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_addr_o=0x01.
REQ-037 SHALL cover (MEM_DEPTH=200): WR_ADDR 0xC8 -> addr_err=1 one cycle, wr_addr_o unchanged.
REQ-038 SHALL cover (AUTO_INC_EN undefined): RD_ADDR 0x05, three RD_DATA -> three tx_valid pulses, all dout=mem[0x05], rd_addr_o=0x05.
